core_mem_requester: RTL and testbench

//  Core-side initiator for the shared instruction/data RAM arbiter: one instance per core.

---
 rtl/core_mem_requester.sv | 193 +++++++++++++++++++
 tb/tb_core_mem_requester.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/core_mem_requester.sv
// core_mem_requester
// Core-side initiator for the shared instruction/data RAM arbiter, one instance
// per core. It takes one access at a time from the core and drives this core's
// rden/wren/address/din lanes to the arbiter. It then waits for this core's acq
// bit and, for reads, captures this core's byte lane of Dq. The result, or a
// timeout error, goes back to the core over a valid/ready response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_valid/req_* come from the core and are accepted while
// req_ready=1. resp_valid/resp_rdata/resp_err are held stable from the cycle
// resp_valid rises until the edge where resp_ready is also 1.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   req_valid/req_ready     core request handshake
//   req_we/req_addr/req_wdata  access type (1 = write), byte address, write data
//   resp_valid/resp_ready   core response handshake
//   resp_rdata/resp_err     read data (0 for writes and errors), timeout flag
//   rden/wren               this core's request bits to the arbiter
//   mem_addr/mem_din        this core's lane LANE of the arbiter Address/Din buses
//   acq_in/dq_in            this core's grant bit, and lane LANE of the arbiter Dq bus
//   dbg_state_o             current FSM state, for observation only
module core_mem_requester #(
    parameter int LANE       = 0,
    parameter int RD_LATENCY = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       rden,
    output logic       wren,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic       acq_in,
    input  logic [7:0] dq_in,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    state_t     state_q, state_d;
    logic       req_ready_q, req_ready_d;
    logic       rden_q, rden_d;
    logic       wren_q, wren_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic       rvalid_q, rvalid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        rden_d      = rden_q;
        wren_d      = wren_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_d = 1'b0;

        // LANE only selects the arbiter bus slice at the instantiation site.
        assert (LANE >= 0 && LANE <= 7 && RD_LATENCY >= 1 && RD_LATENCY <= 15
                && TIMEOUT >= 2 && TIMEOUT <= 255);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d      = req_we;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    tmo_cnt_d = 8'd0;
                    rden_d    = ~req_we;
                    wren_d    = req_we;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // tmo_cnt is 0 only in the first REQ cycle. The arbiter's acq
                // is registered and may still be high from a previous access,
                // so it is not trusted until the second cycle.
                if (tmo_cnt_q != 8'd0 && acq_in) begin
                    rden_d = 1'b0;
                    wren_d = 1'b0;
                    if (we_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = 8'd0;
                        err_d    = 1'b0;
                        state_d  = RESP;
                    end else begin
                        lat_cnt_d = LAT_INIT;
                        state_d   = WAIT_DATA;
                    end
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    rden_d   = 1'b0;
                    wren_d   = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = 8'd0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            WAIT_DATA: begin
                if (lat_cnt_q == 4'd0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = dq_in;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    rdata_d  = 8'd0;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // req_ready is registered so that it reads 0 in the cycle after a reset edge.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            tmo_cnt_q   <= 8'd0;
            lat_cnt_q   <= 4'd0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rden        = rden_q;
    assign wren        = wren_q;
    assign mem_addr    = addr_q;
    assign mem_din     = wdata_q;
    assign resp_valid  = rvalid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_core_mem_requester.sv
// Bench for core_mem_requester (RD_LATENCY=2, TIMEOUT=8). A driver task issues
// each access and plays the arbiter (acq_in, dq_in), then pushes the hand-computed
// {err, rdata} into exp_q. A negedge monitor pops it and compares on every response handshake.
module tb_core_mem_requester;

    localparam int RD_LAT = 2;
    localparam int TMO    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_ready, resp_err;
    logic [7:0] resp_rdata;
    logic       rden, wren, acq_in;
    logic [7:0] mem_addr, mem_din, dq_in;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    core_mem_requester #(.LANE(0), .RD_LATENCY(RD_LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rden(rden), .wren(wren), .mem_addr(mem_addr), .mem_din(mem_din),
        .acq_in(acq_in), .dq_in(dq_in), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rden"}, rden, 0);
        check({name, "_wren"}, wren, 0);
        check({name, "_req_ready"}, req_ready, 0);
        check({name, "_resp_valid"}, resp_valid, 0);
        check({name, "_resp_rdata"}, resp_rdata, 0);
        check({name, "_resp_err"}, resp_err, 0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_mem_din"}, mem_din, 0);
    endtask

    // Scoreboard monitor: compares each response at its handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (rden && wren) begin
                errors++;
                $display("FAIL rden_wren_both: got 1 expected 0 (t=%0t)", $time);
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got err=%0b rdata=%0h expected none", resp_err, resp_rdata);
                end else begin
                    automatic logic [8:0] e = exp_q.pop_front();
                    if ({resp_err, resp_rdata} !== e) begin
                        errors++;
                        $display("FAIL resp: got err=%0b rdata=%0h expected err=%0b rdata=%0h",
                                 resp_err, resp_rdata, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    // grant: REQ cycle (1-based) with acq_in=1, 0 = never. stuck: acq_in high throughout REQ.
    // hold: cycles resp_ready is held low. rst_wait: reset in WAIT_DATA and drop the access.
    task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] dq, input int grant, input bit stuck,
                           input int hold, input bit rst_wait, input logic [8:0] exp,
                           input int exp_cycles);
        int c;
        int guard;
        if (!rst_wait) exp_q.push_back(exp);
        acq_in    = stuck;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        c = 0;
        while ((rden || wren) && c < 40) begin
            c++;
            check("lane_addr", mem_addr, addr);
            check("rden_dir", rden, !we);
            check("wren_dir", wren, we);
            if (we) check("lane_din", mem_din, wdata);
            check("req_ready_busy", req_ready, 0);
            acq_in = stuck || (c == grant);
            tick();
        end
        acq_in = 1'b0;
        check("req_cycles", c, exp_cycles);
        if (!we && grant != 0) begin
            if (rst_wait) begin
                rst_n = 1'b0;
                tick();
                check_all_zero("reset_in_wait");
                rst_n = 1'b1;
                repeat (3) begin
                    tick();
                    check("no_resp_after_reset", resp_valid, 0);
                end
                check("req_ready_after_reset", req_ready, 1);
                return;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                dq_in = ~dq;
                tick();
            end
            dq_in = dq;
            tick();
            dq_in = ~dq;
        end
        if (hold > 0) resp_ready = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("resp_valid_seen", resp_valid, 1);
        check("resp_latency", guard, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", resp_valid, 1);
            check("hold_data", {resp_err, resp_rdata}, exp);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        check("resp_valid_drop", resp_valid, 0);
        check("req_ready_after_resp", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
        req_wdata = 8'h00; resp_ready = 1'b1; acq_in = 1'b0; dq_in = 8'h00;
        repeat (3) tick();
        check_all_zero("reset");
        check("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();
        check("req_ready_post_reset", req_ready, 1);

        // read, grant on REQ cycle 2, A5 on the capture edge
        run_txn(1'b0, 8'h20, 8'h00, 8'hA5, 2, 1'b0, 0, 1'b0, {1'b0, 8'hA5}, 2);
        // write 3C to 10, grant on cycle 4
        run_txn(1'b1, 8'h10, 8'h3C, 8'h00, 4, 1'b0, 0, 1'b0, {1'b0, 8'h00}, 4);
        // stale acq high: cycle 1 ignored, grant on cycle 2
        run_txn(1'b0, 8'h33, 8'h00, 8'h5E, 2, 1'b1, 0, 1'b0, {1'b0, 8'h5E}, 2);
        // no grant ever: timeout after 8 REQ cycles
        run_txn(1'b0, 8'h44, 8'h00, 8'hFF, 0, 1'b0, 0, 1'b0, {1'b1, 8'h00}, TMO);
        // no grant on a write also times out
        run_txn(1'b1, 8'h45, 8'h77, 8'h00, 0, 1'b0, 0, 1'b0, {1'b1, 8'h00}, TMO);
        // response back-pressure for 5 cycles
        run_txn(1'b0, 8'h55, 8'h00, 8'hC3, 3, 1'b0, 5, 1'b0, {1'b0, 8'hC3}, 3);
        // reset during WAIT_DATA, then a normal read
        run_txn(1'b0, 8'h66, 8'h00, 8'h99, 2, 1'b0, 0, 1'b1, {1'b0, 8'h00}, 2);
        run_txn(1'b0, 8'h66, 8'h00, 8'h99, 2, 1'b0, 0, 1'b0, {1'b0, 8'h99}, 2);

        repeat (2) tick();
        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
